// File: rtl/mem_access.sv
// mem_access: MEM stage of the RV64 pipeline.
//  Takes the EX-stage ALU result either as an effective address or as a
//  pass-through result. Aligned loads and stores go out on the data bus. The
//  stage forms byte strobes and lane-shifted store data, and it sign- or
//  zero-extends load data. Misaligned accesses never reach the bus.
// Ports:
//  clk, reset      clock, synchronous active-high reset
//  in_*            EX/MEM instruction fields (held by upstream while stall_out)
//  mem_read/write  load / store (store wins if both are set)
//  mem_size        0=byte 1=half 2=word 3=dword; mem_unsigned selects zero-extend
//  flush           squash the instruction in this stage
//  stall_out       hold EX/MEM and all upstream stages
//  out_*           registered result to MEM/WB (out_valid is a one-cycle pulse)
//  dreq_*          data bus request, held stable until dresp_data_ok
//  dresp_*         bus completion and raw 64-bit read lane data
module mem_access #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic [XLEN-1:0] in_addr,
  input  logic [XLEN-1:0] in_wdata,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic [1:0]      mem_size,
  input  logic            mem_unsigned,
  input  logic            flush,
  output logic            stall_out,
  output logic            out_valid,
  output logic [XLEN-1:0] out_data,
  output logic            out_misaligned,
  output logic            dreq_valid,
  output logic [XLEN-1:0] dreq_addr,
  output logic [7:0]      dreq_strobe,
  output logic [XLEN-1:0] dreq_data,
  output logic [1:0]      dreq_size,
  input  logic            dresp_data_ok,
  input  logic [XLEN-1:0] dresp_data
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  logic [0:0]      state;
  logic            squash;
  logic            req_load;
  logic            req_unsigned;

  logic            memop, aligned, accept;
  logic [2:0]      amask;
  logic [7:0]      sbase;
  logic [5:0]      sh_in, sh_req;
  logic [XLEN-1:0] ld_shift, ld_ext;

  // Sign- or zero-extend the low bytes of the already-shifted read data.
  function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] d,
                                             input logic [1:0] sz,
                                             input logic u);
    case (sz)
      2'd0:    extend = {{(XLEN-8){d[7]  & ~u}}, d[7:0]};
      2'd1:    extend = {{(XLEN-16){d[15] & ~u}}, d[15:0]};
      2'd2:    extend = {{(XLEN-32){d[31] & ~u}}, d[31:0]};
      default: extend = d;
    endcase
  endfunction

  always_comb begin
    memop = mem_read | mem_write;
    amask = 3'd0;
    sbase = 8'h01;
    case (mem_size)
      2'd0:    begin amask = 3'd0; sbase = 8'h01; end
      2'd1:    begin amask = 3'd1; sbase = 8'h03; end
      2'd2:    begin amask = 3'd3; sbase = 8'h0F; end
      default: begin amask = 3'd7; sbase = 8'hFF; end
    endcase
    aligned  = (in_addr[2:0] & amask) == 3'd0;
    accept   = (state == S_IDLE) & in_valid & ~flush & memop & aligned;
    sh_in    = {in_addr[2:0], 3'b000};
    sh_req   = {dreq_addr[2:0], 3'b000};
    ld_shift = dresp_data >> sh_req;
    ld_ext   = extend(ld_shift, dreq_size, req_unsigned);
    // While busy, the stall drops in the completion cycle. This lets upstream
    // advance so that a new instruction reaches IDLE on the next cycle.
    stall_out = (state == S_BUSY) ? ~dresp_data_ok : accept;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      squash         <= 1'b0;
      req_load       <= 1'b0;
      req_unsigned   <= 1'b0;
      out_valid      <= 1'b0;
      out_data       <= '0;
      out_misaligned <= 1'b0;
      dreq_valid     <= 1'b0;
      dreq_addr      <= '0;
      dreq_strobe    <= 8'h00;
      dreq_data      <= '0;
      dreq_size      <= 2'd0;
    end else begin
      out_valid      <= 1'b0;
      out_misaligned <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid && !flush) begin
            if (!memop) begin
              out_valid <= 1'b1;
              out_data  <= in_addr;
            end else if (!aligned) begin
              out_valid      <= 1'b1;
              out_misaligned <= 1'b1;
              out_data       <= '0;
            end else begin
              state        <= S_BUSY;
              dreq_valid   <= 1'b1;
              dreq_addr    <= in_addr;
              dreq_size    <= mem_size;
              req_load     <= ~mem_write;
              req_unsigned <= mem_unsigned;
              dreq_strobe  <= mem_write ? (sbase << in_addr[2:0]) : 8'h00;
              dreq_data    <= in_wdata << sh_in;
            end
          end
        end
        default: begin
          if (dresp_data_ok) begin
            state      <= S_IDLE;
            dreq_valid <= 1'b0;
            squash     <= 1'b0;
            // The bus cannot abort. A squashed access still waits for its
            // completion, and then its result is discarded.
            if (!(squash || flush)) begin
              out_valid <= 1'b1;
              out_data  <= req_load ? ld_ext : '0;
            end
          end else if (flush) begin
            squash <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [63:0] in_addr, in_wdata;
  logic        mem_read, mem_write, mem_unsigned, flush;
  logic [1:0]  mem_size;
  logic        stall_out, out_valid, out_misaligned;
  logic [63:0] out_data;
  logic        dreq_valid;
  logic [63:0] dreq_addr, dreq_data;
  logic [7:0]  dreq_strobe;
  logic [1:0]  dreq_size;
  logic        dresp_data_ok;
  logic [63:0] dresp_data;

  int n_cmp = 0;
  int n_err = 0;

  mem_access #(.XLEN(64)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_addr(in_addr),
    .in_wdata(in_wdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_size(mem_size), .mem_unsigned(mem_unsigned), .flush(flush),
    .stall_out(stall_out), .out_valid(out_valid), .out_data(out_data),
    .out_misaligned(out_misaligned), .dreq_valid(dreq_valid),
    .dreq_addr(dreq_addr), .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dreq_size(dreq_size), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: plain arithmetic from the byte-lane rules.
  function automatic logic [7:0] m_strobe(input logic [1:0] sz, input int off);
    int nb = 1 << sz;
    logic [15:0] m = (16'd1 << nb) - 16'd1;
    return 8'(m << off);
  endfunction

  function automatic logic [63:0] m_load(input logic [63:0] resp, input int off,
                                         input logic [1:0] sz, input logic u);
    int nbits = 8 * (1 << sz);
    logic [63:0] v = resp >> (8 * off);
    logic [63:0] mask;
    if (nbits == 64) return v;
    mask = (64'd1 << nbits) - 64'd1;
    v = v & mask;
    if (!u && v[nbits-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; flush = 0; mem_read = 0; mem_write = 0;
    mem_size = 0; mem_unsigned = 0; dresp_data_ok = 0;
  endtask

  // Run one instruction to completion. k is the cycle count from accept to
  // data_ok. A nonzero fl_at flushes in that busy cycle, where fl_at < k.
  task automatic do_op(input logic [63:0] a, input logic [63:0] wd, input logic rd,
                       input logic wr, input logic [1:0] sz, input logic u,
                       input int k, input int fl_at, input logic [63:0] resp);
    int off = int'(a[2:0]);
    logic memop = rd | wr;
    logic mis = (a % (64'd1 << sz)) != 0;
    logic squashed = 0;
    logic [63:0] exp;
    in_valid = 1; flush = 0; in_addr = a; in_wdata = wd; mem_read = rd;
    mem_write = wr; mem_size = sz; mem_unsigned = u;
    if (!memop || mis) begin
      @(negedge clk); check("idle_stall", {63'd0, stall_out}, 64'd0);
      tick(); in_valid = 0;
      @(negedge clk);
      check("short_valid", {63'd0, out_valid}, 64'd1);
      check("short_mis", {63'd0, out_misaligned}, {63'd0, memop});
      check("short_data", out_data, memop ? 64'd0 : a);
      check("short_noreq", {63'd0, dreq_valid}, 64'd0);
      tick();
      return;
    end
    @(negedge clk); check("accept_stall", {63'd0, stall_out}, 64'd1);
    tick();
    for (int i = 1; i <= k; i++) begin
      if (i == fl_at) begin flush = 1; squashed = 1; end
      if (i == k) begin dresp_data_ok = 1; dresp_data = resp; end
      else dresp_data = {$urandom, $urandom};
      @(negedge clk);
      check("req_valid", {63'd0, dreq_valid}, 64'd1);
      check("req_addr", dreq_addr, a);
      check("req_size", {62'd0, dreq_size}, {62'd0, sz});
      check("req_strobe", {56'd0, dreq_strobe}, wr ? {56'd0, m_strobe(sz, off)} : 64'd0);
      if (wr) check("req_data", dreq_data, wd << (8 * off));
      check("busy_stall", {63'd0, stall_out}, (i == k) ? 64'd0 : 64'd1);
      tick(); flush = 0;
    end
    dresp_data_ok = 0; in_valid = 0;
    exp = wr ? 64'd0 : m_load(resp, off, sz, u);
    @(negedge clk);
    check("done_valid", {63'd0, out_valid}, squashed ? 64'd0 : 64'd1);
    if (!squashed) check("done_data", out_data, exp);
    check("done_reqoff", {63'd0, dreq_valid}, 64'd0);
    tick();
    check("pulse_off", {63'd0, out_valid}, 64'd0);
  endtask

  initial begin
    idle_inputs(); in_addr = 0; in_wdata = 0; dresp_data = 0;
    reset = 1;
    tick(); tick();
    reset = 0;
    @(negedge clk);
    check("rst_valid", {63'd0, out_valid}, 64'd0);
    check("rst_data", out_data, 64'd0);
    check("rst_mis", {63'd0, out_misaligned}, 64'd0);
    check("rst_req", {63'd0, dreq_valid}, 64'd0);
    check("rst_strobe", {56'd0, dreq_strobe}, 64'd0);
    check("rst_stall", {63'd0, stall_out}, 64'd0);
    tick();

    // Directed cases
    do_op(64'h1234, 64'd0, 0, 0, 2'd0, 0, 1, 0, 64'd0);
    do_op(64'h1003, 64'd0, 1, 0, 2'd0, 0, 3, 0, 64'h0000_0000_8000_0000);
    check("lb_sext", m_load(64'h0000_0000_8000_0000, 3, 2'd0, 0), 64'hFFFF_FFFF_FFFF_FF80);
    do_op(64'h2006, 64'hBEEF, 0, 1, 2'd1, 0, 2, 0, 64'd0);
    check("sh_strobe", {56'd0, m_strobe(2'd1, 6)}, 64'hC0);
    do_op(64'h3002, 64'd0, 1, 0, 2'd2, 0, 1, 0, 64'd0);
    do_op(64'h4008, 64'd0, 1, 0, 2'd3, 0, 3, 1, 64'h55);
    do_op(64'h4010, 64'd0, 1, 0, 2'd3, 0, 2, 0, 64'hDEAD_BEEF_0123_4567);

    // A flush in IDLE suppresses both the result and the request.
    in_valid = 1; flush = 1; mem_read = 1; mem_size = 0; in_addr = 64'h10;
    @(negedge clk); check("flush_idle_stall", {63'd0, stall_out}, 64'd0);
    tick(); idle_inputs();
    @(negedge clk);
    check("flush_idle_valid", {63'd0, out_valid}, 64'd0);
    check("flush_idle_req", {63'd0, dreq_valid}, 64'd0);
    tick();

    // A reset in BUSY drops the request.
    in_valid = 1; mem_read = 1; mem_size = 2'd2; in_addr = 64'h5004;
    tick(); tick();
    reset = 1; idle_inputs();
    tick(); reset = 0;
    @(negedge clk);
    check("rstbusy_req", {63'd0, dreq_valid}, 64'd0);
    check("rstbusy_stall", {63'd0, stall_out}, 64'd0);
    check("rstbusy_valid", {63'd0, out_valid}, 64'd0);
    tick();
    do_op(64'h6001, 64'd0, 1, 0, 2'd0, 1, 1, 0, 64'h0000_0000_0000_F700);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      logic [63:0] a = {$urandom, $urandom};
      logic [1:0]  sz = 2'($urandom_range(0, 3));
      logic [1:0]  kind = 2'($urandom_range(0, 3));
      int k = $urandom_range(1, 4);
      int fl = 0;
      if ($urandom_range(0, 9) < 7) a = a & ~((64'd1 << sz) - 64'd1);
      if (k >= 2 && $urandom_range(0, 4) == 0) fl = $urandom_range(1, k - 1);
      do_op(a, {$urandom, $urandom}, kind[0], kind[1], sz, 1'($urandom_range(0, 1)),
            k, fl, {$urandom, $urandom});
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk); check("gap_valid", {63'd0, out_valid}, 64'd0);
        tick();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
